imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Byte-stream program loader for the single-cycle processor's instruction memory.
//  Accepts bytes on a valid/ready handshake and assembles them little-endian into 32-bit instructions.
//  Drives the memory write port (we/waddr/wdata) and holds the CPU in reset while loading.
//  Provides the run-time write path into the memory that the CPU fetches from via komut = mem[pc/4].
// PARAMETERS
//  DEPTH      32     instruction memory size in 32-bit words
//  BASE_ADDR  32'd0  byte address of the first word written (multiple of 4)
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  start       in   1   one-cycle request to begin a load; sampled only in IDLE
//  word_count  in   16  number of words to load; latched when start is accepted
//  rx_valid    in   1   byte source has data
//  rx_data     in   8   byte from the source
//  rx_ready    out  1   loader accepts a byte this cycle
//  we          out  1   instruction memory write enable, one cycle per word
//  waddr       out  32  byte address of the write (BASE_ADDR + 4*word index)
//  wdata       out  32  assembled instruction
//  cpu_hold    out  1   high while loading; OR it into the processor reset
//  busy        out  1   state != IDLE
//  done        out  1   one-cycle pulse when a load completes
//  err         out  1   sticky error: word_count > DEPTH; cleared by next accepted start
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE; all outputs 0; byte/word counters cleared.
//  FSM states: IDLE, RECV, WRITE, DONE. All outputs are registered or decoded from state.
//  IDLE: rx_ready=0. On start=1:
//    word_count==0     -> DONE, with no writes
//    word_count>DEPTH  -> err=1, stay IDLE, no writes, no done
//    otherwise         -> latch count, clear err, byte_idx=0, word_idx=0, go to RECV
//  RECV: rx_ready=1. A byte is transferred when rx_valid & rx_ready.
//    byte k (0..3) goes into wdata[8k+7:8k]; the first byte is the LSB.
//    rx_valid gaps stall without side effects.
//    The 4th transfer goes to WRITE on the next edge.
//  WRITE: exactly one cycle. we=1, rx_ready=0, waddr=BASE_ADDR+4*word_idx, wdata stable.
//    Then word_idx++. If this was the last word (word_idx==count-1) go to DONE, else RECV.
//  DONE: done=1 for one cycle, then IDLE.
//  cpu_hold=1 in RECV, WRITE and DONE; it falls together with done.
//  Latency: we is asserted the cycle after the 4th byte handshake.
//    Best-case throughput is 5 cycles/word.
//  start while busy: ignored; word_count is not re-latched.
//  Outside WRITE: we=0. waddr/wdata keep their last value.
//  Reset mid-load: the partial word is discarded and no write is issued.
//    Words already written stay in memory. The next load starts again at BASE_ADDR.
//  Width rules:
//    word_idx is clog2(DEPTH+1) bits; it cannot wrap because count <= DEPTH.
//    waddr is computed in 32 bits.
// TESTING
//  1. Assert reset=0 mid-run -> all outputs 0 immediately, without waiting for clk.
//  2. count=1, bytes 13,05,50,00 back-to-back:
//     -> single we, waddr=0x0, wdata=0x00500513; done the next cycle; cpu_hold falls with done.
//  3. count=3 with random rx_valid gaps:
//     -> writes at 0x0/0x4/0x8 with correct data; rx_ready=0 during every WRITE cycle.
//  4. count=0 -> done pulses with no we. count=33 (DEPTH=32) -> err=1, no we, no done.
//     A following valid start clears err.
//  5. Reset after 2 bytes of word 1 -> no we. A new count=1 load writes 0x0 with fresh data only.
//  6. start pulsed during RECV with word_count=5 -> ignored; the original count of 2 completes.
//     Also a full DEPTH=32 load: last waddr=0x7C.

Source files
------------

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Bundles the two buses of the instruction-memory loader:
//     * the incoming byte stream (rx_valid / rx_data / rx_ready)
//     * the instruction-memory write port (we / waddr / wdata)
//
//   Handshake: a byte moves on a rising clock edge where rx_valid and
//   rx_ready are both high. The source holds rx_data stable while rx_valid
//   is high and the byte has not yet been taken. rx_ready does not depend
//   on rx_valid in the same cycle.
//
//   Modports
//     master : the byte source and the memory. It drives rx_valid and
//              rx_data, and it observes rx_ready and the write port.
//     slave  : the loader. It consumes bytes and drives the write port.
//
//   Signals
//     rx_valid  1   byte source has data
//     rx_data   8   byte from the source
//     rx_ready  1   loader accepts a byte this cycle
//     we        1   instruction memory write enable
//     waddr     32  byte address of the write
//     wdata     32  assembled instruction
// -----------------------------------------------------------------------------
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  we,
        input  waddr,
        input  wdata
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output we,
        output waddr,
        output wdata
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Byte-stream program loader for the single-cycle processor's instruction
//   memory. Bytes arrive on a valid/ready handshake and are assembled
//   little-endian into 32-bit instructions. Each finished word is written
//   through the memory write port. The CPU is held in reset while a load
//   is in progress.
//
//   Parameters
//     DEPTH      instruction memory size in 32-bit words
//     BASE_ADDR  byte address of the first word written (multiple of 4)
//
//   Ports
//     clk         in   1   system clock, rising edge
//     reset       in   1   asynchronous, active-low reset
//     start       in   1   one-cycle load request, sampled only in IDLE
//     word_count  in   16  words to load, latched when start is accepted
//     bus         slave    byte stream in, memory write port out
//     cpu_hold    out  1   high while loading; OR into the processor reset
//     busy        out  1   loader is not idle
//     done        out  1   one-cycle pulse when a load completes
//     err         out  1   sticky: requested count exceeded DEPTH
//     fsm_state   out  2   current FSM state (debug visibility)
//
//   Timing
//     A word costs at least 4 byte cycles plus 1 WRITE cycle, so the best
//     case is 5 cycles per word. we rises the cycle after the 4th byte
//     handshake.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   word_count,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    fsm_state
);

    // word_idx counts up to DEPTH and never past it, so it needs
    // clog2(DEPTH+1) bits and cannot wrap.
    localparam int IDX_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      byte_buf;
    logic [31:0]      waddr_q;
    logic [31:0]      wdata_q;
    logic             err_q;

    logic             xfer;
    logic             last_word;
    logic             too_big;
    logic [31:0]      word_addr;

    // rx_ready is decoded from state only, so a byte moves whenever
    // the source offers one during RECV.
    assign xfer      = (state == S_RECV) && bus.rx_valid;
    assign last_word = (word_idx == (count_q - IDX_W'(1)));
    assign too_big   = (32'(word_count) > 32'(DEPTH));
    assign word_addr = BASE_ADDR + (32'(word_idx) << 2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            count_q  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            byte_buf <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count == 16'd0) begin
                            // An empty load still completes with a done pulse.
                            err_q <= 1'b0;
                            state <= S_DONE;
                        end else if (too_big) begin
                            // Refused: stay idle and leave the memory untouched.
                            err_q <= 1'b1;
                        end else begin
                            count_q  <= word_count[IDX_W-1:0];
                            err_q    <= 1'b0;
                            byte_idx <= '0;
                            word_idx <= '0;
                            state    <= S_RECV;
                        end
                    end
                end

                S_RECV: begin
                    if (xfer) begin
                        case (byte_idx)
                            2'd0: byte_buf[7:0]   <= bus.rx_data;
                            2'd1: byte_buf[15:8]  <= bus.rx_data;
                            2'd2: byte_buf[23:16] <= bus.rx_data;
                            default: begin
                                // Last byte completes the word. The write port
                                // registers change only here, so between writes
                                // they keep the last written address and data.
                                wdata_q <= {bus.rx_data, byte_buf};
                                waddr_q <= word_addr;
                                state   <= S_WRITE;
                            end
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                    end
                end

                S_WRITE: begin
                    word_idx <= word_idx + IDX_W'(1);
                    state    <= last_word ? S_DONE : S_RECV;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready = (state == S_RECV);
    assign bus.we       = (state == S_WRITE);
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;

    // cpu_hold covers RECV, WRITE and DONE, so it falls in the same edge as done.
    assign cpu_hold  = (state != S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int DEPTH = 32;
    localparam logic [31:0] BASE = 32'd0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_count = 16'd0;
    logic        cpu_hold, busy, done, err;
    logic [1:0]  fsm_state;

    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_writes = 0;
    int n_dones = 0;
    logic [31:0] last_waddr = 32'd0;
    logic [63:0] exp_q[$];
    logic [31:0] mem_exp[DEPTH];
    logic [31:0] mem_obs[DEPTH];
    logic        prev_done = 1'b0;

    typedef struct {
        int   count;
        int   gap;
        logic exp_err;
        int   exp_writes;
        int   exp_done;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-port monitor and done/cpu_hold relationship checks.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.we) begin
                n_writes++;
                last_waddr = bus.waddr;
                check("rx_ready_in_write", 64'(bus.rx_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: waddr=0x%0h wdata=0x%0h, none expected",
                             bus.waddr, bus.wdata);
                end else begin
                    check("write_addr_data", {bus.waddr, bus.wdata}, exp_q.pop_front());
                end
                if (bus.waddr[31:2] < DEPTH) mem_obs[bus.waddr[6:2]] = bus.wdata;
            end
            if (done) begin
                n_dones++;
                check("hold_with_done", 64'(cpu_hold), 64'd1);
            end
            if (prev_done) check("hold_done_fall", {62'd0, done, cpu_hold}, 64'd0);
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        int waited;
        g = $urandom_range(0, max_gap);
        repeat (g) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        waited = 0;
        while (!bus.rx_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.rx_ready) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: rx_ready stayed 0 for %0d cycles", waited);
        end else begin
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
    endtask

    // Model: word i of a load lands at BASE + 4*i with bytes packed LSB first.
    task automatic expect_word(input logic [31:0] w, input int idx);
        exp_q.push_back({BASE + 32'(idx) * 32'd4, w});
        mem_exp[idx] = w;
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input int max_gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
        expect_word(w, idx);
    endtask

    task automatic do_start(input int cnt);
        start = 1'b1;
        word_count = 16'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        word_count = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles", busy, n);
        end
    endtask

    task automatic run_load(input int cnt, input int gap);
        do_start(cnt);
        if (cnt > 0 && cnt <= DEPTH)
            for (int i = 0; i < cnt; i++) send_word($urandom, i, gap);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int w0, d0;
        logic [31:0] w;

        for (int i = 0; i < DEPTH; i++) begin
            mem_exp[i] = 32'd0;
            mem_obs[i] = 32'd0;
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;

        vecs[0] = '{count: 1,   gap: 0, exp_err: 1'b0, exp_writes: 1,  exp_done: 1};
        vecs[1] = '{count: 3,   gap: 3, exp_err: 1'b0, exp_writes: 3,  exp_done: 1};
        vecs[2] = '{count: 0,   gap: 0, exp_err: 1'b0, exp_writes: 0,  exp_done: 1};
        vecs[3] = '{count: 33,  gap: 0, exp_err: 1'b1, exp_writes: 0,  exp_done: 0};
        vecs[4] = '{count: 2,   gap: 1, exp_err: 1'b0, exp_writes: 2,  exp_done: 1};
        vecs[5] = '{count: 32,  gap: 0, exp_err: 1'b0, exp_writes: 32, exp_done: 1};
        vecs[6] = '{count: 100, gap: 0, exp_err: 1'b1, exp_writes: 0,  exp_done: 0};
        vecs[7] = '{count: 4,   gap: 4, exp_err: 1'b0, exp_writes: 4,  exp_done: 1};
        vecs[8] = '{count: 32,  gap: 2, exp_err: 1'b0, exp_writes: 32, exp_done: 1};

        // Reset state.
        #12;
        check("reset_outputs", {58'd0, busy, bus.rx_ready, bus.we, cpu_hold, done, err}, 64'd0);
        check("reset_waddr_wdata", {bus.waddr, bus.wdata}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single word 13,05,50,00 back to back; cycle-exact check.
        do_start(1);
        check("recv_ready", {62'd0, bus.rx_ready, cpu_hold}, 64'd3);
        send_word(32'h00500513, 0, 0);
        check("t2_we", 64'(bus.we), 64'd1);
        check("t2_write", {bus.waddr, bus.wdata}, {32'h0, 32'h00500513});
        @(posedge clk); #1;
        check("t2_done_cycle", {61'd0, bus.we, done, cpu_hold}, 64'd3);
        @(posedge clk); #1;
        check("t2_after_done", {61'd0, done, cpu_hold, busy}, 64'd0);
        check("t2_wdata_held", 64'(bus.wdata), 64'h00500513);

        // Reset in the middle of word 1: outputs clear without a clock edge.
        do_start(2);
        send_word($urandom, 0, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        w0 = n_writes;
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {58'd0, busy, bus.rx_ready, bus.we, cpu_hold, done, err}, 64'd0);
        check("async_reset_bus", {bus.waddr, bus.wdata}, 64'd0);
        #3;
        reset = 1'b1;
        @(posedge clk); #1;
        check("no_write_after_reset", 64'(n_writes - w0), 64'd0);
        w0 = n_writes;
        w = $urandom;
        do_start(1);
        send_word(w, 0, 1);
        wait_idle();
        check("fresh_load_writes", 64'(n_writes - w0), 64'd1);
        check("fresh_load_mem0", 64'(mem_obs[0]), 64'(w));

        // start during RECV is ignored; the original count of 2 completes.
        w0 = n_writes;
        d0 = n_dones;
        do_start(2);
        w = $urandom;
        send_byte(w[7:0], 0);
        start = 1'b1;
        word_count = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 4; k++) send_byte(w[8*k +: 8], 1);
        expect_word(w, 0);
        send_word($urandom, 1, 1);
        wait_idle();
        check("busy_start_writes", 64'(n_writes - w0), 64'd2);
        check("busy_start_dones", 64'(n_dones - d0), 64'd1);

        // Table-driven loads with random data and gaps.
        foreach (vecs[i]) begin
            w0 = n_writes;
            d0 = n_dones;
            run_load(vecs[i].count, vecs[i].gap);
            @(posedge clk); #1;
            check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_writes", i), 64'(n_writes - w0), 64'(vecs[i].exp_writes));
            check($sformatf("vec%0d_dones", i), 64'(n_dones - d0), 64'(vecs[i].exp_done));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
            if (vecs[i].count == DEPTH)
                check($sformatf("vec%0d_last_waddr", i), 64'(last_waddr), 64'h7C);
        end

        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("mem[%0d]", i), 64'(mem_obs[i]), 64'(mem_exp[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
